// File: rtl/test_in_inf_pkg.sv
`default_nettype none
// ============================================================================
// Module : test_in_inf_pkg
// Brief  : Shared constants and helpers for the source-side test interface.
//          Holds the timestamp width used by both the source and sink sides.
// Rev    : 1.0  initial release
// ============================================================================
package test_in_inf_pkg;

  // Timestamp width shared with the sink-side interface
  localparam int TS_WIDTH = 10;

  // Default virtual-channel count and matching select width
  localparam int N_VCS   = 2;
  localparam int VC_BITS = 1;

  // Wrap-safe "ts <= now": the modular distance now - ts lies in the lower
  // half of the timestamp space.
  function automatic logic ts_is_due(input logic [TS_WIDTH-1:0] now,
                                     input logic [TS_WIDTH-1:0] ts);
    logic [TS_WIDTH-1:0] diff;
    diff = now - ts;
    return ~diff[TS_WIDTH-1];
  endfunction

endpackage : test_in_inf_pkg
`default_nettype wire

// File: rtl/test_in_inf_ts_fifo.sv
`default_nettype none
// ============================================================================
// Module : ts_fifo
// Brief  : DEPTH x WIDTH synchronous FIFO holding pending flit timestamps.
//          Head is presented combinationally; extra pointer bit tells
//          full from empty.
// Rev    : 1.0  initial release
// ============================================================================
module ts_fifo
  import test_in_inf_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int LOG_DEPTH = 2,
  parameter int WIDTH     = TS_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [LOG_DEPTH:0] r_wr_ptr;
  logic [LOG_DEPTH:0] r_rd_ptr;
  logic               w_do_push;
  logic               w_do_pop;

  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[LOG_DEPTH] != r_rd_ptr[LOG_DEPTH]) &&
                     (r_wr_ptr[LOG_DEPTH-1:0] == r_rd_ptr[LOG_DEPTH-1:0]);
  assign head      = r_mem[r_rd_ptr[LOG_DEPTH-1:0]];
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  // Pointer update; reset empties the queue immediately
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage write; contents are don't-care while the queue is empty
  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr[LOG_DEPTH-1:0]] <= din;
  end

endmodule : ts_fifo
`default_nettype wire

// File: rtl/test_in_inf.sv
`default_nettype none
// ============================================================================
// Module : test_in_inf
// Brief  : Source-side test interface. Per-VC queues of timestamped flits are
//          released once due against sim_time and downstream credit allows.
//          ready drops while any due flit is still waiting.
// Rev    : 1.0  initial release
// ============================================================================
module test_in_inf
  import test_in_inf_pkg::*;
#(
  parameter int nVCs      = N_VCS,
  parameter int VC_BITS   = test_in_inf_pkg::VC_BITS,
  parameter int DEPTH     = 4,
  parameter int LOG_DEPTH = 2,
  parameter int CREDITS   = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [TS_WIDTH-1:0]      sim_time,
  input  logic                     load_valid,
  input  logic [VC_BITS-1:0]       load_vc,
  input  logic [TS_WIDTH-1:0]      load_ts,
  output logic                     load_ready,
  input  logic [nVCs-1:0]          credit,
  output logic [nVCs*TS_WIDTH-1:0] flit_ts,
  output logic [nVCs-1:0]          flit_valid,
  output logic                     ready
);

  localparam int c_cnt_w = $clog2(CREDITS + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(CREDITS);
  localparam logic [c_cnt_w:0]   c_cnt_max  = (c_cnt_w + 1)'(CREDITS);

  logic [nVCs-1:0][TS_WIDTH-1:0] w_head;
  logic [nVCs-1:0]               w_full;
  logic [nVCs-1:0]               w_empty;
  logic [nVCs-1:0]               w_push;
  logic [nVCs-1:0]               w_due;
  logic [nVCs-1:0]               w_send;
  logic                          w_load_ready;
  logic [nVCs-1:0][c_cnt_w-1:0]  w_cnt_next;
  logic [nVCs-1:0]               w_cnt_ovf;
  logic [c_cnt_w:0]              w_cnt_sum;

  logic [nVCs-1:0][c_cnt_w-1:0]  r_cnt;
  logic [nVCs-1:0]               r_flit_valid;
  logic [nVCs*TS_WIDTH-1:0]      r_flit_ts;

  // One timestamp queue per virtual channel
  for (genvar v = 0; v < nVCs; v++) begin : g_vc
    ts_fifo #(
      .DEPTH     (DEPTH),
      .LOG_DEPTH (LOG_DEPTH),
      .WIDTH     (TS_WIDTH)
    ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (w_push[v]),
      .din   (load_ts),
      .pop   (w_send[v]),
      .head  (w_head[v]),
      .full  (w_full[v]),
      .empty (w_empty[v])
    );
  end

  // Load acceptance: out-of-range VCs are never ready, so they are dropped
  always_comb begin
    w_load_ready = 1'b0;
    w_push       = '0;
    for (int v = 0; v < nVCs; v++) begin
      if (int'(load_vc) == v) begin
        w_load_ready = ~w_full[v];
        w_push[v]    = load_valid & ~w_full[v];
      end
    end
  end

  // A VC sends when its head is due and at least one downstream slot is free
  always_comb begin
    w_due  = '0;
    w_send = '0;
    for (int v = 0; v < nVCs; v++) begin
      w_due[v]  = ~w_empty[v] & ts_is_due(sim_time, w_head[v]);
      w_send[v] = w_due[v] & (r_cnt[v] != '0);
    end
  end

  // Credit bookkeeping: spend on send, refund on credit, clamp at capacity
  always_comb begin
    w_cnt_next = r_cnt;
    w_cnt_ovf  = '0;
    w_cnt_sum  = '0;
    for (int v = 0; v < nVCs; v++) begin
      w_cnt_sum = {1'b0, r_cnt[v]}
                - {{c_cnt_w{1'b0}}, w_send[v]}
                + {{c_cnt_w{1'b0}}, credit[v]};
      if (w_cnt_sum > c_cnt_max) begin
        w_cnt_next[v] = c_cnt_init;
        w_cnt_ovf[v]  = 1'b1;
      end else begin
        w_cnt_next[v] = w_cnt_sum[c_cnt_w-1:0];
      end
    end
  end

  // Output strobes, held timestamps and credit counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_flit_valid <= '0;
      r_flit_ts    <= '0;
      r_cnt        <= {nVCs{c_cnt_init}};
    end else begin
      r_flit_valid <= w_send;
      r_cnt        <= w_cnt_next;
      for (int v = 0; v < nVCs; v++) begin
        if (w_send[v]) r_flit_ts[v*TS_WIDTH +: TS_WIDTH] <= w_head[v];
      end
    end
  end

`ifndef SYNTHESIS
  // Credit returned beyond buffer capacity is a downstream protocol violation
  always @(posedge clock) begin
    if (!reset) begin
      assert (w_cnt_ovf == '0)
        else $error("test_in_inf: credit counter overflow on VCs %b", w_cnt_ovf);
    end
  end
`endif

  assign load_ready = w_load_ready;
  assign flit_valid = r_flit_valid;
  assign flit_ts    = r_flit_ts;
  assign ready      = ~|w_due;

endmodule : test_in_inf
`default_nettype wire

// File: tb/tb_test_in_inf.sv
`default_nettype none
// ============================================================================
// Module : tb_test_in_inf
// Brief  : Directed self-checking bench for test_in_inf (2 VCs, depth 4,
//          4 credits, 10-bit timestamps).
// Rev    : 1.0  initial release
// ============================================================================
module tb_test_in_inf;
  import test_in_inf_pkg::*;

  localparam int NV = 2;
  localparam int VB = 1;
  localparam int TW = TS_WIDTH;

  logic               clock      = 1'b0;
  logic               reset      = 1'b1;
  logic [TW-1:0]      sim_time   = '0;
  logic               load_valid = 1'b0;
  logic [VB-1:0]      load_vc    = '0;
  logic [TW-1:0]      load_ts    = '0;
  logic               load_ready;
  logic [NV-1:0]      credit     = '0;
  logic [NV*TW-1:0]   flit_ts;
  logic [NV-1:0]      flit_valid;
  logic               ready;

  int n_vec = 0;
  int n_bad = 0;

  test_in_inf #(
    .nVCs      (NV),
    .VC_BITS   (VB),
    .DEPTH     (4),
    .LOG_DEPTH (2),
    .CREDITS   (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .sim_time   (sim_time),
    .load_valid (load_valid),
    .load_vc    (load_vc),
    .load_ts    (load_ts),
    .load_ready (load_ready),
    .credit     (credit),
    .flit_ts    (flit_ts),
    .flit_valid (flit_valid),
    .ready      (ready)
  );

  // 100 MHz clock
  always #5 clock = ~clock;

  // Single comparison point for every check
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one cycle; land just after the rising edge
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input int vc, input int ts);
    load_valid = 1'b1;
    load_vc    = VB'(vc);
    load_ts    = TW'(ts);
    step();
    load_valid = 1'b0;
  endtask

  task automatic do_reset();
    load_valid = 1'b0;
    credit     = '0;
    reset      = 1'b1;
    step();
    step();
    reset      = 1'b0;
  endtask

  // Run a number of cycles counting flit strobes per VC
  task automatic run(input int cycles, output int n0, output int n1);
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (flit_valid[0]) n0++;
      if (flit_valid[1]) n1++;
    end
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "tb_test_in_inf watchdog expired");
  end

  initial begin
    int a0, a1, b0, b1, c0, c1;

    // ---- 1: reset state ----
    #2;
    chk("rst_flit_valid", 32'(flit_valid), 0);
    chk("rst_flit_ts",    32'(flit_ts),    0);
    chk("rst_ready",      32'(ready),      1);
    chk("rst_load_ready", 32'(load_ready), 1);
    step();
    step();
    reset = 1'b0;

    // ---- 2: single flit, becomes due when sim_time reaches ts ----
    sim_time = 10'd3;
    load(0, 5);
    chk("t2_not_due_ready", 32'(ready), 1);
    step();
    chk("t2_not_due_valid", 32'(flit_valid), 0);
    sim_time = 10'd5;
    #1;
    chk("t2_due_ready", 32'(ready), 0);
    step();
    chk("t2_flit_valid", 32'(flit_valid), 1);
    chk("t2_flit_ts0",   32'(flit_ts[9:0]), 5);
    chk("t2_ready_after", 32'(ready), 1);
    step();
    chk("t2_valid_drop", 32'(flit_valid), 0);
    chk("t2_ts_hold",    32'(flit_ts[9:0]), 5);

    // ---- 3: credit exhaustion on VC1, then credit returns ----
    do_reset();
    sim_time = '0;
    a1 = 0;
    for (int i = 0; i < 6; i++) begin
      load_valid = 1'b1;
      load_vc    = 1'b1;
      load_ts    = '0;
      step();
      if (flit_valid[1]) a1++;
    end
    load_valid = 1'b0;
    run(8, b0, b1);
    chk("t3_pulses_no_credit", 32'(a1 + b1), 4);
    chk("t3_ready_blocked",    32'(ready), 0);
    credit = 2'b10;
    run(1, a0, a1);
    credit = 2'b00;
    run(1, b0, b1);
    credit = 2'b10;
    run(1, c0, c1);
    credit = 2'b00;
    a1 = a1 + b1 + c1;
    run(6, b0, b1);
    chk("t3_pulses_credit", 32'(a1 + b1), 2);
    chk("t3_ready_drained", 32'(ready), 1);

    // ---- 4: queue full back-pressure ----
    do_reset();
    sim_time = '0;
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1;
      load_vc    = 1'b0;
      load_ts    = 10'd100;
      #1;
      chk("t4_lr_open", 32'(load_ready), 1);
      step();
    end
    #1;
    chk("t4_lr_full", 32'(load_ready), 0);
    step();
    load_vc = 1'b1;
    #1;
    chk("t4_lr_vc1", 32'(load_ready), 1);
    step();
    load_valid = 1'b0;
    sim_time = 10'd100;
    run(10, a0, a1);
    chk("t4_vc0_count", 32'(a0), 4);
    chk("t4_vc1_count", 32'(a1), 1);

    // ---- 5: timestamp wrap ----
    do_reset();
    sim_time = 10'd1020;
    load(0, 2);
    for (int t = 1020; t < 1024; t++) begin
      sim_time = TW'(t);
      #1;
      chk("t5_wrap_ready", 32'(ready), 1);
      step();
      chk("t5_wrap_valid", 32'(flit_valid), 0);
    end
    sim_time = 10'd0;
    step();
    chk("t5_at0_valid", 32'(flit_valid), 0);
    sim_time = 10'd2;
    #1;
    chk("t5_due_ready", 32'(ready), 0);
    step();
    chk("t5_flit_valid", 32'(flit_valid), 1);
    chk("t5_flit_ts0",   32'(flit_ts[9:0]), 2);

    // ---- 6: simultaneous VCs, credit during send, mid-stream reset ----
    do_reset();
    sim_time = '0;
    load(0, 7);
    load(1, 9);
    sim_time = 10'd50;
    #1;
    chk("t6_ready_due", 32'(ready), 0);
    step();
    chk("t6_both_valid", 32'(flit_valid), 3);
    chk("t6_both_ts",    32'(flit_ts), (9 * 1024) + 7);
    // VC0 now holds 3 credits; a credit coinciding with the first send keeps it at 3
    sim_time = '0;
    for (int i = 0; i < 4; i++) load(0, 7);
    sim_time = 10'd50;
    credit = 2'b01;
    run(1, a0, a1);
    credit = 2'b00;
    run(8, b0, b1);
    chk("t6_credit_and_send", 32'(a0 + b0), 4);
    chk("t6_ready_idle",      32'(ready), 1);
    // VC0 credits exhausted, VC1 has 3 left
    sim_time = '0;
    load(1, 60);
    load(1, 60);
    load(0, 60);
    sim_time = 10'd60;
    step();
    chk("t6_pre_reset_valid", 32'(flit_valid), 2);
    reset = 1'b1;
    #1;
    chk("t6_async_valid", 32'(flit_valid), 0);
    chk("t6_async_ts",    32'(flit_ts),    0);
    chk("t6_async_ready", 32'(ready),      1);
    step();
    step();
    reset = 1'b0;
    run(6, a0, a1);
    chk("t6_flushed", 32'(a0 + a1), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_test_in_inf
`default_nettype wire
